// File: rtl/plm_rd_pkg.sv
// Shared types and default widths for the PLM burst reader and its output FIFO.
package plm_rd_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 13;
   localparam int LEN_W_DEF  = 14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } rd_state_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  last;
   } fifo_entry_t;

endpackage

// File: rtl/plm_rd_fifo.sv
// Small synchronous FIFO of {data, last} entries; the head is read combinationally
// so the stream output is valid in the same cycle the entry becomes visible.
module plm_rd_fifo
   import plm_rd_pkg::*;
#(
   parameter  int DATA_W     = DATA_W_DEF,
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              head_last,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;
   logic [DATA_W:0]  head_entry;

   assign pop_ok  = pop && (count_q != '0);
   // A push into a full FIFO is fine as long as the head leaves in the same cycle.
   assign push_ok = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {push_data, push_last};
      end
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign head_data  = empty ? '0 : head_entry[DATA_W:1];
   assign head_last  = empty ? 1'b0 : head_entry[0];

endmodule

// File: rtl/plm_burst_reader.sv
// Burst read front end for a 1W+1R PLM wrapper: issues one read per cycle, never
// alongside a write, and streams the captured words out through a credit-managed FIFO.
module plm_burst_reader
   import plm_rd_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              busy,
   output logic              mem_ce1,
   output logic [ADDR_W-1:0] mem_a1,
   input  logic [DATA_W-1:0] mem_q1,
   input  logic              wr_ce0
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              pop_fire;
   logic [CNT_W:0]    credit_used;
   logic              issue;
   logic              drain_done;

   assign pop_fire    = out_valid && out_ready;
   // Words already buffered plus the one arriving next cycle must leave room for another.
   assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
   assign issue       = (state_q == ST_RUN) && (remaining_q != '0) && !wr_ce0
                        && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign drain_done  = !inflight_q
                        && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop_fire));

   always_comb begin
      state_d         = state_q;
      cur_addr_d      = cur_addr_q;
      remaining_d     = remaining_q;
      inflight_d      = issue;
      inflight_last_d = issue && (remaining_q == LEN_W'(1));
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cur_addr_d  = req_addr;
               remaining_d = req_len;
               state_d     = (req_len == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               cur_addr_d  = cur_addr_q + ADDR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_done) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q         <= ST_IDLE;
         cur_addr_q      <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cur_addr_q      <= cur_addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   plm_rd_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .push      (inflight_q),
      .push_data (mem_q1),
      .push_last (inflight_last_q),
      .pop       (pop_fire),
      .head_data (out_data),
      .head_last (out_last),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign mem_ce1   = issue;
   assign mem_a1    = issue ? cur_addr_q : '0;

endmodule

// File: tb/tb_plm_burst_reader.sv
// Directed bench for plm_burst_reader with a 1-cycle-latency SRAM model on the read port.
module tb_plm_burst_reader;
   import plm_rd_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [12:0] req_addr = '0;
   logic [13:0] req_len = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        out_last;
   logic        done;
   logic        busy;
   logic        mem_ce1;
   logic [12:0] mem_a1;
   logic [63:0] mem_q1 = '0;
   logic        wr_ce0 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc_k = 0;
   int          done_cnt = 0;
   int          done_k = 0;
   int          first_valid_k = 0;
   logic        hold_check = 1'b0;
   logic [63:0] hold_exp = '0;
   logic [12:0] iss_addr[$];
   int          iss_k[$];
   fifo_entry_t got[$];

   plm_burst_reader dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done),
      .busy      (busy),
      .mem_ce1   (mem_ce1),
      .mem_a1    (mem_a1),
      .mem_q1    (mem_q1),
      .wr_ce0    (wr_ce0)
   );

   always #5 CLK = ~CLK;

   function automatic logic [63:0] mem_fn(input logic [12:0] a);
      return {16'hC0DE, 3'b000, a, 19'h5A5A5, a ^ 13'h1ABC};
   endfunction

   // SRAM read port: registered output, holds last value when not enabled.
   always @(posedge CLK) begin
      if (mem_ce1) mem_q1 <= mem_fn(mem_a1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h (k=%0d)", tag, obs, exp, cyc_k);
      end
   endtask

   always @(negedge CLK) begin
      if (RSTN) begin
         if (mem_ce1) begin
            iss_addr.push_back(mem_a1);
            iss_k.push_back(cyc_k);
         end
         if (wr_ce0) check("ce1_during_wr", {63'd0, mem_ce1}, 64'd0);
         if (out_valid && first_valid_k == 0) first_valid_k = cyc_k;
         if (out_valid && out_ready) got.push_back('{data: out_data, last: out_last});
         if (hold_check && out_valid) check("stall_hold", out_data, hold_exp);
         if (done) begin
            done_cnt++;
            done_k = cyc_k;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_out_last"},  {63'd0, out_last},  64'd0);
      check({tag, "_out_data"},  out_data,           64'd0);
      check({tag, "_done"},      {63'd0, done},      64'd0);
      check({tag, "_busy"},      {63'd0, busy},      64'd0);
      check({tag, "_mem_ce1"},   {63'd0, mem_ce1},   64'd0);
      check({tag, "_mem_a1"},    {51'd0, mem_a1},    64'd0);
   endtask

   task automatic clear_obs();
      iss_addr.delete();
      iss_k.delete();
      got.delete();
      done_cnt      = 0;
      done_k        = 0;
      first_valid_k = 0;
      hold_check    = 1'b0;
   endtask

   // Called just after a posedge with the DUT idle; the request is accepted at the next edge.
   task automatic send_req(input logic [12:0] addr, input logic [13:0] len);
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      cyc_k     = 0;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic do_burst(input logic [12:0] addr, input logic [13:0] len,
                           input int stall, input logic [63:0] wr_mask);
      int k;
      clear_obs();
      hold_exp = mem_fn(addr);
      send_req(addr, len);
      for (k = 1; k <= 300; k++) begin
         cyc_k      = k;
         wr_ce0     = (k < 64) ? wr_mask[k] : 1'b0;
         out_ready  = (k > stall);
         hold_check = (k <= stall);
         @(posedge CLK);
         #1;
         if (done_cnt != 0) break;
      end
      check("done_seen", {63'd0, done_cnt != 0}, 64'd1);
      cyc_k      = k + 1;
      wr_ce0     = 1'b0;
      out_ready  = 1'b1;
      hold_check = 1'b0;
      @(negedge CLK);
      check("req_ready_after", {63'd0, req_ready}, 64'd1);
      check("busy_after", {63'd0, busy}, 64'd0);
      @(posedge CLK);
      #1;
      check("done_once", done_cnt, 64'd1);
   endtask

   task automatic verify_words(input logic [12:0] addr, input int len);
      logic [12:0] a;
      check("n_issues", iss_addr.size(), len);
      check("n_words", got.size(), len);
      for (int i = 0; i < len; i++) begin
         a = addr + 13'(i);
         if (i < iss_addr.size()) check("issue_addr", {51'd0, iss_addr[i]}, {51'd0, a});
         if (i < got.size()) begin
            check("word_data", got[i].data, mem_fn(a));
            check("word_last", {63'd0, got[i].last}, {63'd0, i == len - 1});
         end
      end
   endtask

   initial begin
      int n_early;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs("rst");
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      @(posedge CLK);
      #1;

      // Basic burst: issues k1..k4, first word visible k3, last transfer k6, done k7.
      do_burst(13'h0010, 14'd4, 0, 64'd0);
      verify_words(13'h0010, 4);
      if (iss_k.size() == 4) begin
         check("basic_first_issue_k", iss_k[0], 64'd1);
         check("basic_last_issue_k", iss_k[3], 64'd4);
      end
      check("basic_first_valid_k", first_valid_k, 64'd3);
      check("basic_done_k", done_k, 64'd7);

      // Address wrap at the top of the wrapper.
      do_burst(13'h1FFE, 14'd4, 0, 64'd0);
      verify_words(13'h1FFE, 4);

      // Backpressure: only FIFO_DEPTH reads may be outstanding while out_ready is low.
      do_burst(13'h0200, 14'd16, 10, 64'd0);
      verify_words(13'h0200, 16);
      n_early = 0;
      foreach (iss_k[i]) if (iss_k[i] <= 10) n_early++;
      check("stall_issues", n_early, 64'd4);

      // Write conflict on RUN cycles 2 and 5 pushes the 8th issue out to k10.
      do_burst(13'h0400, 14'd8, 0, 64'h24);
      verify_words(13'h0400, 8);
      if (iss_k.size() == 8) check("wr_last_issue_k", iss_k[7], 64'd10);

      // Zero length: straight to FIN.
      do_burst(13'h0555, 14'd0, 0, 64'd0);
      check("zero_issues", iss_addr.size(), 64'd0);
      check("zero_words", got.size(), 64'd0);
      check("zero_valid_seen", first_valid_k, 64'd0);
      check("zero_done_k", done_k, 64'd1);

      // Reset in the middle of a long burst.
      clear_obs();
      send_req(13'h0300, 14'd32);
      out_ready = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         cyc_k = k;
         @(posedge CLK);
         #1;
         if (got.size() >= 10) break;
      end
      check("midrst_words_before", got.size(), 64'd10);
      RSTN = 1'b0;
      #2;
      check_reset_outputs("midrst");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs("midrst_hold");
      check("midrst_no_done", done_cnt, 64'd0);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      @(posedge CLK);
      #1;
      do_burst(13'h0100, 14'd2, 0, 64'd0);
      verify_words(13'h0100, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
